// File: rtl/pipefft_twid_pkg.sv
// Shared types and default widths for the pipeFFT twiddle RAM loader.
package pipefft_twid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_SLICE_W = 16;
    localparam int DEF_DEPTH   = 4;

endpackage

// File: rtl/pipefft_twid_pack.sv
// Slice counter plus LSB-first packing register; word_next is the word as it
// will look once the currently offered slice is accepted.
module pipefft_twid_pack #(
    parameter int SLICE_W = 16,
    parameter int SLICES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic [SLICE_W-1:0]         data,
    output logic [SLICES*SLICE_W-1:0]  word_next,
    output logic                       last
);

    localparam int CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    logic [SLICES*SLICE_W-1:0] pack;
    logic [CNT_W-1:0]          cnt;

    always_comb begin
        word_next = pack;
        word_next[cnt*SLICE_W +: SLICE_W] = data;
    end

    assign last = (cnt == CNT_W'(SLICES-1));

    // clr wins over en so a slice accepted alongside a restart is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack <= '0;
            cnt  <= '0;
        end else if (clr) begin
            cnt  <= '0;
        end else if (en) begin
            pack <= word_next;
            cnt  <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipefft_twid_loader.sv
// Write-side master for the stage twiddle RAM: packs SLICE_W slices into
// DATA_W words and writes DEPTH of them at ascending addresses.
module pipefft_twid_loader
    import pipefft_twid_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [SLICE_W-1:0] in_data,
    output logic               in_ready,
    output logic [DATA_W-1:0]  wD,
    output logic [ADDR_W-1:0]  wAddr,
    output logic               wEn,
    output logic               busy,
    output logic               done,
    output logic               err_unexp
);

    localparam int SLICES = DATA_W / SLICE_W;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word_next;
    logic              last;
    logic              accept;
    logic              clr;

    assign accept = (state == ST_FILL) && in_valid;
    // Leaving WRITE also resets the slice count for the next word
    assign clr    = start || (state == ST_WRITE);

    assign in_ready = (state == ST_FILL);
    assign busy     = (state == ST_FILL) || (state == ST_WRITE);
    assign wEn      = (state == ST_WRITE);
    assign done     = (state == ST_DONE);

    pipefft_twid_pack #(
        .SLICE_W (SLICE_W),
        .SLICES  (SLICES)
    ) u_pack (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (accept),
        .data      (in_data),
        .word_next (word_next),
        .last      (last)
    );

    // wD/wAddr latch when the word completes so they hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            wD        <= '0;
            wAddr     <= '0;
            err_unexp <= 1'b0;
        end else if (start) begin
            state     <= ST_FILL;
            addr      <= '0;
            err_unexp <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) err_unexp <= 1'b1;
                end
                ST_FILL: begin
                    if (accept && last) begin
                        state <= ST_WRITE;
                        wD    <= word_next;
                        wAddr <= addr;
                    end
                end
                ST_WRITE: begin
                    if (addr == ADDR_W'(DEPTH-1)) begin
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipefft_twid_loader.sv
// Directed bench for pipefft_twid_loader: a per-cycle vector table for the
// basic load, then hand-written sequences for the multi-cycle corner cases.
module tb_pipefft_twid_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [63:0] wD;
    logic [1:0]  wAddr;
    logic        wEn;
    logic        busy;
    logic        done;
    logic        err_unexp;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [1:0]  wq_a[$];
    logic [63:0] wq_d[$];

    pipefft_twid_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wD        (wD),
        .wAddr     (wAddr),
        .wEn       (wEn),
        .busy      (busy),
        .done      (done),
        .err_unexp (err_unexp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        vld;
        logic [15:0] data;
        logic        e_rdy;
        logic        e_busy;
        logic        e_wen;
        logic        e_done;
        logic [1:0]  e_wa;
        logic [63:0] e_wd;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [15:0] base, input int w);
        logic [15:0] b;
        b = base + 16'(4*w);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic step(input logic s, input logic v, input logic [15:0] d);
        @(negedge clk);
        start = s; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
        if (wEn) begin
            wq_a.push_back(wAddr);
            wq_d.push_back(wD);
        end
        if (done) done_cnt++;
    endtask

    // Feeds one full 16-slice load (start already issued); data = base+i
    task automatic feed_load(input logic [15:0] base, input bit gaps);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 16'h0);
                step(1'b0, 1'b1, base + 16'(4*w + k));
                chk("wen_timing", wEn, (k == 3));
                if (k == 3) chk("write_word", {wAddr, wD}, {2'(w), word_of(base, w)});
            end
            step(1'b0, 1'b0, 16'h0);
            chk("done_pulse", {done, busy}, (w == 3) ? 2'b10 : 2'b01);
        end
    endtask

    task automatic chk_queue(input string name, input logic [15:0] base, input int first);
        for (int i = 0; i < 4; i++) begin
            if (first + i < wq_a.size())
                chk(name, {wq_a[first+i], wq_d[first+i]}, {2'(i), word_of(base, i)});
            else
                chk(name, 0, 1);
        end
    endtask

    initial begin
        // Vector table for the basic back-to-back load of 0x0001..0x0010
        tbl[0] = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 64'h0};
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (k < 3)
                    tbl[1+5*w+k] = '{1'b0, 1'b1, 16'(4*w+k+1), 1'b1, 1'b1, 1'b0, 1'b0,
                                     (w > 0) ? 2'(w-1) : 2'd0,
                                     (w > 0) ? word_of(16'h1, w-1) : 64'h0};
                else
                    tbl[1+5*w+k] = '{1'b0, 1'b1, 16'(4*w+k+1), 1'b0, 1'b1, 1'b1, 1'b0,
                                     2'(w), word_of(16'h1, w)};
            end
            // Slice offered during WRITE must be ignored
            if (w < 3)
                tbl[5+5*w] = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0, 2'(w), word_of(16'h1, w)};
            else
                tbl[5+5*w] = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, word_of(16'h1, 3)};
        end
        tbl[21] = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, word_of(16'h1, 3)};

        // Reset state
        #12;
        chk("reset_outputs", {in_ready, wEn, busy, done, err_unexp, wAddr, wD}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Basic load
        for (int r = 0; r < 22; r++) begin
            step(tbl[r].start, tbl[r].vld, tbl[r].data);
            chk($sformatf("basic_row%0d", r), {in_ready, busy, wEn, done, wAddr, wD},
                {tbl[r].e_rdy, tbl[r].e_busy, tbl[r].e_wen, tbl[r].e_done, tbl[r].e_wa, tbl[r].e_wd});
        end
        chk("done_slice_no_err", err_unexp, 1'b0);
        chk("basic_nwrites", wq_a.size(), 4);
        step(1'b0, 1'b0, 16'h0);

        // Backpressure with random gaps
        wq_a.delete(); wq_d.delete();
        step(1'b1, 1'b0, 16'h0);
        feed_load(16'h0001, 1'b1);
        chk("gaps_nwrites", wq_a.size(), 4);
        step(1'b0, 1'b0, 16'h0);

        // Restart mid-fill after 6 slices; slice alongside start is dropped
        wq_a.delete(); wq_d.delete();
        step(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h00A0 + 16'(i));
        step(1'b0, 1'b0, 16'h0);
        for (int i = 4; i < 6; i++) step(1'b0, 1'b1, 16'h00A0 + 16'(i));
        step(1'b1, 1'b1, 16'h0BAD);
        chk("restart_state", {busy, in_ready, wEn}, 3'b110);
        feed_load(16'h0200, 1'b0);
        chk("restart_nwrites", wq_a.size(), 5);
        if (wq_a.size() > 0) chk("restart_first", {wq_a[0], wq_d[0]}, {2'd0, word_of(16'h00A0, 0)});
        chk_queue("restart_words", 16'h0200, 1);
        step(1'b0, 1'b0, 16'h0);

        // Unexpected data in IDLE: sticky until next start
        step(1'b0, 1'b1, 16'h1234);
        chk("err_set", err_unexp, 1'b1);
        step(1'b0, 1'b0, 16'h0);
        chk("err_held", err_unexp, 1'b1);
        step(1'b1, 1'b0, 16'h0);
        chk("err_cleared", {err_unexp, busy}, 2'b01);

        // Async reset between 2nd and 3rd writes
        wq_a.delete(); wq_d.delete();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 16'h0300 + 16'(4*w + k));
            step(1'b0, 1'b0, 16'h0);
        end
        step(1'b0, 1'b1, 16'h0308);
        step(1'b0, 1'b1, 16'h0309);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset", {in_ready, wEn, busy, done, err_unexp, wAddr, wD}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h030A + 16'(i));
            chk("post_reset_idle", {wEn, in_ready, busy}, 3'b000);
        end
        chk("reset_nwrites", wq_a.size(), 2);
        wq_a.delete(); wq_d.delete();
        step(1'b1, 1'b0, 16'h0);
        feed_load(16'h0400, 1'b0);
        chk_queue("fresh_load", 16'h0400, 0);

        // Back-to-back: start in the DONE cycle
        wq_a.delete(); wq_d.delete();
        done_cnt = 0;
        step(1'b1, 1'b0, 16'h0);
        feed_load(16'h0500, 1'b0);
        step(1'b1, 1'b0, 16'h0);
        chk("b2b_restart", {done, busy, in_ready}, 3'b011);
        feed_load(16'h0600, 1'b0);
        step(1'b0, 1'b0, 16'h0);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_nwrites", wq_a.size(), 8);
        chk_queue("b2b_first", 16'h0500, 0);
        chk_queue("b2b_second", 16'h0600, 4);
        chk("final_idle", {busy, done, wEn, in_ready}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
